// File: rtl/branch_predictor.sv
// Dynamic branch predictor: direct-mapped BTB with 2-bit saturating counters,
// combinational fetch prediction, Execute-stage resolve/update and redirect.
module branch_predictor #(
  parameter int DATA_WIDTH = 32,
  parameter int ENTRIES    = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] PCF_i,
  output logic                  PredTakenF_o,
  output logic [DATA_WIDTH-1:0] PredTargetF_o,
  input  logic                  BranchE_i,
  input  logic                  StallE_i,
  input  logic [DATA_WIDTH-1:0] PCE_i,
  input  logic                  BranchTaken_i,
  input  logic [DATA_WIDTH-1:0] TargetE_i,
  input  logic                  PredTakenE_i,
  input  logic [DATA_WIDTH-1:0] PredTargetE_i,
  output logic                  Mispredict_o,
  output logic [DATA_WIDTH-1:0] RedirectPC_o,
  output logic                  FlushD_o,
  output logic                  FlushE_o,
  output logic [31:0]           BranchCount_o,
  output logic [31:0]           MispredCount_o
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = DATA_WIDTH - IDX_W - 2;

  localparam logic [1:0] CTR_SNT = 2'b00;
  localparam logic [1:0] CTR_WNT = 2'b01;
  localparam logic [1:0] CTR_WT  = 2'b10;
  localparam logic [1:0] CTR_ST  = 2'b11;

  logic                  valid_reg  [ENTRIES];
  logic [1:0]            ctr_reg    [ENTRIES];
  logic [TAG_W-1:0]      tag_reg    [ENTRIES];
  logic [DATA_WIDTH-1:0] target_reg [ENTRIES];

  logic [31:0] branch_count_reg;
  logic [31:0] mispred_count_reg;

  logic [IDX_W-1:0] idx_f;
  logic [IDX_W-1:0] idx_e;
  logic [TAG_W-1:0] tag_f;
  logic [TAG_W-1:0] tag_e;
  logic             hit_f;
  logic             hit_e;
  logic             res;

  logic             wr_en;
  logic             wr_alloc;
  logic             wr_target;
  logic [1:0]       ctr_next;
  logic [ENTRIES-1:0] wr_sel;

  // Byte offset within a word never participates in lookup.
  logic [1:0] unused_pc_bits;
  assign unused_pc_bits = PCF_i[1:0];

  assign idx_f = PCF_i[IDX_W+1:2];
  assign tag_f = PCF_i[DATA_WIDTH-1:IDX_W+2];
  assign idx_e = PCE_i[IDX_W+1:2];
  assign tag_e = PCE_i[DATA_WIDTH-1:IDX_W+2];

  // Fetch lookup reads the registered table, so same-cycle updates are not bypassed.
  assign hit_f         = valid_reg[idx_f] && (tag_reg[idx_f] == tag_f);
  assign PredTakenF_o  = hit_f && ctr_reg[idx_f][1];
  assign PredTargetF_o = hit_f ? target_reg[idx_f] : '0;

  assign res   = BranchE_i && !StallE_i;
  assign hit_e = valid_reg[idx_e] && (tag_reg[idx_e] == tag_e);

  always_comb begin
    wr_en     = 1'b0;
    wr_alloc  = 1'b0;
    wr_target = 1'b0;
    ctr_next  = ctr_reg[idx_e];
    if (res) begin
      if (hit_e) begin
        wr_en = 1'b1;
        if (BranchTaken_i) begin
          wr_target = 1'b1;
          ctr_next  = (ctr_reg[idx_e] == CTR_ST) ? CTR_ST : ctr_reg[idx_e] + 2'd1;
        end else begin
          ctr_next  = (ctr_reg[idx_e] == CTR_SNT) ? CTR_SNT : ctr_reg[idx_e] - 2'd1;
        end
      end else if (BranchTaken_i) begin
        wr_en     = 1'b1;
        wr_alloc  = 1'b1;
        wr_target = 1'b1;
        ctr_next  = CTR_WT;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < ENTRIES; gi++) begin : g_sel
      assign wr_sel[gi] = wr_en && (idx_e == IDX_W'(gi));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_reg[i] <= 1'b0;
        ctr_reg[i]   <= CTR_WNT;
      end
    end else begin
      for (int i = 0; i < ENTRIES; i++) begin
        if (wr_sel[i]) begin
          ctr_reg[i] <= ctr_next;
          if (wr_alloc) valid_reg[i] <= 1'b1;
        end
      end
    end
  end

  // Tag and target carry no reset; a cleared valid bit masks them.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        if (wr_sel[i] && wr_alloc)  tag_reg[i]    <= tag_e;
        if (wr_sel[i] && wr_target) target_reg[i] <= TargetE_i;
      end
    end
  end

  assign Mispredict_o = res && ((BranchTaken_i != PredTakenE_i) ||
                                (BranchTaken_i && PredTakenE_i && (TargetE_i != PredTargetE_i)));
  assign RedirectPC_o = BranchTaken_i ? TargetE_i : PCE_i + DATA_WIDTH'(4);
  assign FlushD_o     = Mispredict_o;
  assign FlushE_o     = Mispredict_o;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      branch_count_reg  <= '0;
      mispred_count_reg <= '0;
    end else begin
      if (res)          branch_count_reg  <= branch_count_reg + 32'd1;
      if (Mispredict_o) mispred_count_reg <= mispred_count_reg + 32'd1;
    end
  end

  assign BranchCount_o  = branch_count_reg;
  assign MispredCount_o = mispred_count_reg;

endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor: directed scenarios then random traffic against a
// behavioural table model indexed by plain PC arithmetic.
module tb_branch_predictor;

  localparam int DW      = 32;
  localparam int ENTRIES = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] PCF_i;
  logic          PredTakenF_o;
  logic [DW-1:0] PredTargetF_o;
  logic          BranchE_i;
  logic          StallE_i;
  logic [DW-1:0] PCE_i;
  logic          BranchTaken_i;
  logic [DW-1:0] TargetE_i;
  logic          PredTakenE_i;
  logic [DW-1:0] PredTargetE_i;
  logic          Mispredict_o;
  logic [DW-1:0] RedirectPC_o;
  logic          FlushD_o;
  logic          FlushE_o;
  logic [31:0]   BranchCount_o;
  logic [31:0]   MispredCount_o;

  int checks = 0;
  int errors = 0;

  // Reference model: one slot per (pc/4) mod ENTRIES, remembering the whole upper PC.
  bit          m_valid [ENTRIES];
  logic [31:0] m_tag   [ENTRIES];
  logic [31:0] m_tgt   [ENTRIES];
  int          m_ctr   [ENTRIES];
  logic [31:0] m_branches;
  logic [31:0] m_mispreds;

  branch_predictor #(.DATA_WIDTH(DW), .ENTRIES(ENTRIES)) dut (
    .clk(clk), .rst_n(rst_n), .PCF_i(PCF_i),
    .PredTakenF_o(PredTakenF_o), .PredTargetF_o(PredTargetF_o),
    .BranchE_i(BranchE_i), .StallE_i(StallE_i), .PCE_i(PCE_i),
    .BranchTaken_i(BranchTaken_i), .TargetE_i(TargetE_i),
    .PredTakenE_i(PredTakenE_i), .PredTargetE_i(PredTargetE_i),
    .Mispredict_o(Mispredict_o), .RedirectPC_o(RedirectPC_o),
    .FlushD_o(FlushD_o), .FlushE_o(FlushE_o),
    .BranchCount_o(BranchCount_o), .MispredCount_o(MispredCount_o)
  );

  always #5 clk = ~clk;

  function automatic int slot_of(input logic [31:0] pc);
    return int'((pc / 4) % ENTRIES);
  endfunction

  function automatic logic [31:0] line_of(input logic [31:0] pc);
    return pc / (4 * ENTRIES);
  endfunction

  function automatic bit model_hit(input logic [31:0] pc);
    return m_valid[slot_of(pc)] && (m_tag[slot_of(pc)] == line_of(pc));
  endfunction

  function automatic bit model_taken(input logic [31:0] pc);
    return model_hit(pc) && (m_ctr[slot_of(pc)] >= 2);
  endfunction

  function automatic logic [31:0] model_target(input logic [31:0] pc);
    return model_hit(pc) ? m_tgt[slot_of(pc)] : 32'h0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < ENTRIES; i++) begin
      m_valid[i] = 1'b0;
      m_ctr[i]   = 1;
    end
    m_branches = 32'd0;
    m_mispreds = 32'd0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive at the falling edge, check combinational and registered
  // outputs 1 ns later, then advance the model to the state after the rising edge.
  task automatic cycle(input string name, input logic rst, input logic [31:0] pcf,
                       input logic br, input logic stall, input logic [31:0] pce,
                       input logic tk, input logic [31:0] tgt,
                       input logic ptk, input logic [31:0] ptgt);
    bit          res;
    bit          mis;
    int          s;
    logic [31:0] redirect;
    @(negedge clk);
    rst_n = rst; PCF_i = pcf; BranchE_i = br; StallE_i = stall; PCE_i = pce;
    BranchTaken_i = tk; TargetE_i = tgt; PredTakenE_i = ptk; PredTargetE_i = ptgt;
    #1;
    res = br && !stall;
    mis = res && ((tk != ptk) || (tk && ptk && (tgt != ptgt)));
    redirect = tk ? tgt : pce + 32'd4;
    check({name, ".pred_taken"},  {31'd0, PredTakenF_o}, {31'd0, model_taken(pcf)});
    check({name, ".pred_target"}, PredTargetF_o, model_target(pcf));
    check({name, ".mispredict"},  {31'd0, Mispredict_o}, {31'd0, mis});
    check({name, ".flush"},       {30'd0, FlushD_o, FlushE_o}, {30'd0, mis, mis});
    if (mis) check({name, ".redirect"}, RedirectPC_o, redirect);
    check({name, ".branch_cnt"},  BranchCount_o, m_branches);
    check({name, ".mispred_cnt"}, MispredCount_o, m_mispreds);
    $display("[%0t] %s pcf=%h br=%0d stall=%0d pce=%h tk=%0d tgt=%h ptk=%0d mis=%0d predF=%0d/%h",
             $time, name, pcf, br, stall, pce, tk, tgt, ptk, Mispredict_o, PredTakenF_o, PredTargetF_o);
    if (!rst) begin
      model_reset();
    end else if (res) begin
      m_branches++;
      if (mis) m_mispreds++;
      s = slot_of(pce);
      if (model_hit(pce)) begin
        if (tk) begin
          m_ctr[s] = (m_ctr[s] < 3) ? m_ctr[s] + 1 : 3;
          m_tgt[s] = tgt;
        end else begin
          m_ctr[s] = (m_ctr[s] > 0) ? m_ctr[s] - 1 : 0;
        end
      end else if (tk) begin
        m_valid[s] = 1'b1;
        m_tag[s]   = line_of(pce);
        m_tgt[s]   = tgt;
        m_ctr[s]   = 2;
      end
    end
  endtask

  task automatic fetch_only(input string name, input logic [31:0] pcf);
    cycle(name, 1'b1, pcf, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic resolve(input string name, input logic [31:0] pc, input logic tk,
                         input logic [31:0] tgt, input logic ptk, input logic [31:0] ptgt);
    cycle(name, 1'b1, pc, 1'b1, 1'b0, pc, tk, tgt, ptk, ptgt);
  endtask

  initial begin
    logic [31:0] pc;
    logic [31:0] tgt;
    logic        tk;
    logic        ptk;
    logic [31:0] ptgt;

    rst_n = 1'b0; PCF_i = '0; BranchE_i = 1'b0; StallE_i = 1'b0; PCE_i = '0;
    BranchTaken_i = 1'b0; TargetE_i = '0; PredTakenE_i = 1'b0; PredTargetE_i = '0;
    repeat (2) @(posedge clk);
    model_reset();

    fetch_only("reset_state", 32'h100);
    resolve("first_taken", 32'h100, 1'b1, 32'h80, 1'b0, 32'h0);
    fetch_only("alloc_visible", 32'h100);
    for (int i = 0; i < 3; i++)
      resolve("train_taken", 32'h100, 1'b1, 32'h80, 1'b1, 32'h80);
    resolve("nt_from_strong", 32'h100, 1'b0, 32'h80, 1'b1, 32'h80);
    fetch_only("still_taken", 32'h100);
    resolve("nt_to_weak", 32'h100, 1'b0, 32'h80, 1'b1, 32'h80);
    fetch_only("now_not_taken", 32'h100);

    resolve("alias_a", 32'h100, 1'b1, 32'h80, 1'b0, 32'h0);
    resolve("alias_b", 32'h140, 1'b1, 32'h300, 1'b0, 32'h0);
    fetch_only("alias_old_miss", 32'h100);
    fetch_only("alias_new_hit", 32'h140);

    resolve("wrong_target", 32'h140, 1'b1, 32'h240, 1'b1, 32'h200);
    cycle("stalled", 1'b1, 32'h140, 1'b1, 1'b1, 32'h140, 1'b1, 32'h240, 1'b1, 32'h200);
    fetch_only("after_stall", 32'h140);

    cycle("reset_again", 1'b0, 32'h100, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    resolve("sim_alloc", 32'h100, 1'b1, 32'h80, 1'b0, 32'h0);
    resolve("sim_weaken", 32'h100, 1'b0, 32'h80, 1'b1, 32'h80);
    resolve("sim_flip", 32'h100, 1'b1, 32'h80, 1'b0, 32'h80);
    fetch_only("sim_flip_next", 32'h100);
    cycle("reset_on_update", 1'b0, 32'h180, 1'b1, 1'b0, 32'h180, 1'b1, 32'h44, 1'b0, 32'h0);
    fetch_only("reset_dominates", 32'h180);

    for (int n = 0; n < 400; n++) begin
      pc  = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
      tk  = ($urandom_range(0, 99) < 60);
      case ($urandom_range(0, 3))
        0: tgt = 32'h80;
        1: tgt = 32'h200;
        2: tgt = 32'h240;
        default: tgt = $urandom & 32'hFFFF_FFFC;
      endcase
      if ($urandom_range(0, 3) != 0) begin
        ptk  = model_taken(pc);
        ptgt = model_target(pc);
      end else begin
        ptk  = $urandom_range(0, 1) == 1;
        ptgt = ($urandom_range(0, 1) == 1) ? tgt : 32'h200;
      end
      cycle("rand", ($urandom_range(0, 99) != 0), pc, ($urandom_range(0, 99) < 85),
            ($urandom_range(0, 99) < 20), pc, tk, tgt, ptk, ptgt);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
Dynamic branch predictor and redirect controller for the 5-stage pipeline. Combines a direct-mapped branch target buffer with 2-bit saturating counters. Provides a taken/target prediction to Fetch. When the branch unit resolves a conditional branch in Execute, it updates the tables and raises flush/redirect on a mispredict. Keeps performance counters for resolved branches and mispredicts.

Parameters:
DATA_WIDTH, 32, PC/target width
ENTRIES, 16, table depth; power of two, 2..256
IDX_W, $clog2(ENTRIES), index width (derived)
TAG_W, DATA_WIDTH-IDX_W-2, tag width (derived)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  synchronous active-low reset
PCF_i  input  DATA_WIDTH  fetch-stage PC
PredTakenF_o  output  1  fetch prediction: take branch
PredTargetF_o  output  DATA_WIDTH  predicted target (valid when PredTakenF_o=1)
BranchE_i  input  1  valid conditional branch in Execute this cycle
StallE_i  input  1  Execute stalled; suppresses update/count/mispredict
PCE_i  input  DATA_WIDTH  PC of the branch in Execute
BranchTaken_i  input  1  resolved outcome from the branch unit
TargetE_i  input  DATA_WIDTH  computed branch target (PCE+immB)
PredTakenE_i  input  1  prediction carried down the pipe with this branch
PredTargetE_i  input  DATA_WIDTH  predicted target carried down the pipe
Mispredict_o  output  1  resolved path differs from predicted path
RedirectPC_o  output  DATA_WIDTH  correct next PC on mispredict
FlushD_o  output  1  flush IF/ID register
FlushE_o  output  1  flush ID/EX register
BranchCount_o  output  32  resolved-branch counter
MispredCount_o  output  32  mispredict counter

Behaviour:
- Index = PC[IDX_W+1:2]. Tag = PC[DATA_WIDTH-1:IDX_W+2]. PC[1:0] is ignored.
- Per-entry state: valid, tag, target, ctr[1:0]. Counter encoding: 00 strong NT, 01 weak NT, 10 weak T, 11 strong T.
- Fetch read is combinational from PCF_i:
  - hit = valid & tag match.
  - PredTakenF_o = hit & ctr[1].
  - PredTargetF_o = stored target; outputs 0 when not hit.
- Resolve event: res = BranchE_i & ~StallE_i.
- Table update is registered at the clock edge after res:
  - On a tag hit: ctr increments when taken, decrements when not taken, and saturates at 11 and 00. When taken, target is overwritten with TargetE_i.
  - On a miss with taken: allocate or replace the entry. Set valid=1, tag, target=TargetE_i, ctr=10.
  - On a miss with not-taken: no write.
- Mispredict_o is combinational, same cycle as res. It is:
  res & ((BranchTaken_i != PredTakenE_i) | (BranchTaken_i & PredTakenE_i & (TargetE_i != PredTargetE_i)))
- RedirectPC_o = BranchTaken_i ? TargetE_i : PCE_i+4, truncated to DATA_WIDTH with wrap. It is meaningful only when Mispredict_o=1.
- FlushD_o = FlushE_o = Mispredict_o. Zero cycles of added latency; the redirected fetch occurs on the next edge.
- Counters: BranchCount_o increments on each res. MispredCount_o increments on each Mispredict_o. Both wrap modulo 2^32 and are registered.
- Same-index read/write in one cycle: Fetch sees the pre-update entry, with no bypass. The update is visible from the next cycle.
- Reset (rst_n=0 at an edge):
  - All valid bits are cleared; all ctr values are set to 01; both counters are cleared.
  - Targets and tags need not be reset.
  - Reset dominates a simultaneous update.
  - After reset: PredTakenF_o=0 and PredTargetF_o=0.
- Combinational outputs (Mispredict_o, FlushD_o, FlushE_o, RedirectPC_o) follow their inputs and are not gated by rst_n.
- BranchE_i=0 or StallE_i=1: no update, no count, Mispredict_o=0.

Test Plan:
- Reset, then PCF_i=0x100 -> PredTakenF_o=0, PredTargetF_o=0, both counters 0.
- Branch PCE=0x100, taken, target 0x80, PredTakenE=0 -> Mispredict_o=1, RedirectPC_o=0x80, flushes=1. Next cycle PCF_i=0x100 gives PredTakenF_o=1, PredTargetF_o=0x80; MispredCount_o=1.
- Same branch resolved taken 3 more times, then not-taken once (ctr 11 -> 10) -> PredTakenF_o stays 1. A second not-taken (ctr 01) -> PredTakenF_o=0. Not-taken resolution at PCE=0x100 with PredTakenE=1 -> RedirectPC_o=0x104.
- Aliasing, ENTRIES=16: allocate 0x100 (taken), then taken branch at 0x140 (same index) -> entry replaced. PCF_i=0x100 now misses (PredTakenF_o=0); 0x140 hits.
- Wrong target: PredTakenE=1, PredTargetE=0x200, TargetE=0x240, taken -> Mispredict_o=1, RedirectPC_o=0x240. StallE_i=1 with the same inputs -> Mispredict_o=0 and counters unchanged.
- Simultaneous events: PCF_i=PCE_i=0x100 while an update flips ctr 01->10 -> that cycle PredTakenF_o=0, next cycle 1. rst_n=0 on an update edge -> entry stays invalid, counters 0.
